// File: rtl/mac_accumulator.sv
// Fixed-point multiply-accumulate of N_TERMS Q(32-FRAC).FRAC products.
// The 32-bit result is clamped and presented with a one-cycle active-low strobe.
module mac_accumulator #(
  parameter int N_TERMS = 4,
  parameter int FRAC    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] e,
  output logic               en,
  output logic               sat,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  // 48-bit sum plus 8 guard bits, so the final clamp sees the true sign of up to 255 full-scale terms
  localparam int ACC_W = 56;
  localparam logic [7:0] LAST = 8'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] POS_LIM = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
  localparam logic signed [ACC_W-1:0] NEG_LIM = {{(ACC_W-32){1'b1}}, 32'h8000_0000};

  state_t                   state;
  logic        [7:0]        cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [63:0]       prod;
  logic signed [ACC_W-1:0]  term;
  logic                     pos_ovf;
  logic                     neg_ovf;
  logic signed [31:0]       clamped;

  assign prod     = 64'(a) * 64'(b);
  assign term     = ACC_W'(prod >>> FRAC);
  assign pos_ovf  = (acc > POS_LIM);
  assign neg_ovf  = (acc < NEG_LIM);
  assign in_ready = (state == ACC);
  assign busy     = (state != IDLE);

  always_comb begin
    clamped = acc[31:0];
    if (pos_ovf)      clamped = 32'h7FFF_FFFF;
    else if (neg_ovf) clamped = 32'h8000_0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      e     <= '0;
      sat   <= 1'b0;
      en    <= 1'b1;
    end else begin
      en <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc <= acc + term;
            cnt <= cnt + 8'd1;
            if (cnt == LAST) state <= DONE;
          end
        end
        DONE: begin
          e     <= clamped;
          sat   <= pos_ovf | neg_ovf;
          en    <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a 4-term instance and a 1-term instance.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0;
  logic start1 = 1'b0, in_valid1 = 1'b0;
  logic signed [31:0] a = '0, b = '0;
  logic in_ready, en, sat, busy;
  logic signed [31:0] e;
  logic in_ready1, en1, sat1, busy1;
  logic signed [31:0] e1;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int cyc = 0;

  mac_accumulator #(.N_TERMS(4), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .e(e), .en(en), .sat(sat), .busy(busy)
  );

  mac_accumulator #(.N_TERMS(1), .FRAC(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .in_valid(in_valid1),
    .in_ready(in_ready1), .e(e1), .en(en1), .sat(sat1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (en === 1'b0) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full 4-term result from IDLE; optional stalls and a start pulse while in ACC
  task automatic job(input logic [31:0] ta, input logic [31:0] tb2, input int stall,
                     input bit poke, input logic [31:0] exp_e, input logic exp_sat,
                     input string tag);
    int p0;
    p0 = pulses;
    start = 1'b1;
    step();
    start = 1'b0;
    check1({tag, "/busy_start"}, busy, 1'b1);
    a = ta;
    b = tb2;
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b0;
      for (int s = 0; s < stall; s++) begin
        check1({tag, "/busy_stall"}, busy, 1'b1);
        check1({tag, "/en_stall"}, en, 1'b1);
        step();
      end
      in_valid = 1'b1;
      if (poke && t == 1) start = 1'b1;
      check1({tag, "/in_ready"}, in_ready, 1'b1);
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    check1({tag, "/en_done"}, en, 1'b1);
    check1({tag, "/in_ready_done"}, in_ready, 1'b0);
    check1({tag, "/busy_done"}, busy, 1'b1);
    step();
    check1({tag, "/en_strobe"}, en, 1'b0);
    check({tag, "/e"}, e, exp_e);
    check1({tag, "/sat"}, sat, exp_sat);
    check1({tag, "/busy_idle"}, busy, 1'b0);
    step();
    check1({tag, "/en_after"}, en, 1'b1);
    check({tag, "/e_held"}, e, exp_e);
    check1({tag, "/sat_held"}, sat, exp_sat);
    check({tag, "/pulse_count"}, 32'(pulses - p0), 32'd1);
  endtask

  initial begin
    int p0;
    int nh;
    int hits[3];
    hits = '{0, 0, 0};
    nh = 0;

    #12;
    check("rst/e", e, 32'h0);
    check1("rst/en", en, 1'b1);
    check1("rst/sat", sat, 1'b0);
    check1("rst/busy", busy, 1'b0);
    check1("rst/in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check1("idle/busy", busy, 1'b0);

    job(32'h0001_0000, 32'h0002_0000, 0, 1'b0, 32'h0008_0000, 1'b0, "basic");
    job(32'hFFFF_0000, 32'h0003_0000, 0, 1'b0, 32'hFFF4_0000, 1'b0, "signed");
    job(32'h7FFF_0000, 32'h7FFF_0000, 0, 1'b0, 32'h7FFF_FFFF, 1'b1, "sat_pos");
    job(32'h8000_0000, 32'h7FFF_0000, 0, 1'b0, 32'h8000_0000, 1'b1, "sat_neg");
    job(32'h0001_0000, 32'h0002_0000, 3, 1'b0, 32'h0008_0000, 1'b0, "stall");
    job(32'h0001_0000, 32'h0002_0000, 0, 1'b1, 32'h0008_0000, 1'b0, "start_in_acc");

    // Reset after two accepted terms
    p0 = pulses;
    start = 1'b1;
    step();
    start = 1'b0;
    a = 32'h0001_0000;
    b = 32'h0002_0000;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst/e", e, 32'h0);
    check1("midrst/en", en, 1'b1);
    check1("midrst/busy", busy, 1'b0);
    check1("midrst/in_ready", in_ready, 1'b0);
    check1("midrst/sat", sat, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("midrst/no_pulse", 32'(pulses - p0), 32'd0);
    job(32'h0001_0000, 32'h0002_0000, 0, 1'b0, 32'h0008_0000, 1'b0, "after_rst");

    // Single-term instance
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    a = 32'h0001_0000;
    b = 32'h0002_0000;
    in_valid1 = 1'b1;
    check1("n1/in_ready", in_ready1, 1'b1);
    step();
    in_valid1 = 1'b0;
    check1("n1/en_done", en1, 1'b1);
    check1("n1/busy_done", busy1, 1'b1);
    step();
    check1("n1/en_strobe", en1, 1'b0);
    check("n1/e", e1, 32'h0002_0000);
    check1("n1/sat", sat1, 1'b0);
    step();
    check1("n1/en_after", en1, 1'b1);

    // Back-to-back with start and in_valid held high
    a = 32'h0001_0000;
    b = 32'h0002_0000;
    start = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && nh < 3; k++) begin
      step();
      if (en === 1'b0) begin
        hits[nh] = cyc;
        nh++;
        check("b2b/e", e, 32'h0008_0000);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("b2b/pulses_seen", 32'(nh), 32'd3);
    check("b2b/spacing1", 32'(hits[1] - hits[0]), 32'd6);
    check("b2b/spacing2", 32'(hits[2] - hits[1]), 32'd6);
    step();
    step();
    check1("b2b/idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
